// File: rtl/wb_retire_buffer_pkg.sv
// Shared types for the write-back/retire stage: retire FSM state, exception
// code and the width-independent control part of a buffered entry.
package wb_retire_params;

   typedef logic [4:0] ExceptionCode;

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} RetireState;

   // Fixed-width exception/CP0 fields; the data-width-dependent fields live in
   // the top's WBEntry so the buffer follows its own parameters.
   typedef struct packed {
      logic         exc_valid;
      ExceptionCode exc_code;
      logic         delay_slot;
      logic         eret;
      logic         cp0_we;
      logic [4:0]   cp0_addr;
      logic [2:0]   cp0_sel;
   } WBCtrl;

endpackage

// File: rtl/wb_retire_buffer_forward_merge.sv
// Youngest-first byte merge of buffered register results for ID-stage
// forwarding; walks entries oldest to youngest so younger bytes overwrite.
module wb_forward_merge #(
   parameter  int DATA_WIDTH = 32,
   parameter  int ADDR_WIDTH = 5,
   parameter  int DEPTH      = 4,
   localparam int STRB       = DATA_WIDTH / 8,
   localparam int PW         = $clog2(DEPTH),
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic [PW-1:0]                       rd_ptr,
   input  logic [CW-1:0]                       count,
   input  logic [DEPTH-1:0]                    ent_fwd,
   input  logic [DEPTH-1:0][ADDR_WIDTH-1:0]    ent_addr,
   input  logic [DEPTH-1:0][STRB-1:0]          ent_strobe,
   input  logic [DEPTH-1:0][DATA_WIDTH-1:0]    ent_data,
   input  logic [ADDR_WIDTH-1:0]               fwd_addr,
   output logic                                fwd_hit,
   output logic [STRB-1:0]                     fwd_strobe,
   output logic [DATA_WIDTH-1:0]               fwd_data
);

   logic [PW-1:0] idx;

   always_comb begin
      fwd_strobe = '0;
      fwd_data   = '0;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < count && ent_fwd[idx] && ent_addr[idx] == fwd_addr &&
             fwd_addr != '0) begin
            for (int b = 0; b < STRB; b++) begin
               if (ent_strobe[idx][b]) begin
                  fwd_strobe[b]        = 1'b1;
                  fwd_data[b*8 +: 8]   = ent_data[idx][b*8 +: 8];
               end
            end
         end
      end
   end

   assign fwd_hit = |fwd_strobe;

endmodule

// File: rtl/wb_retire_buffer.sv
// In-order retire buffer: retires one entry per cycle to the shared RF port,
// reports exceptions/eret/mtc0 to CP0 and holds a flush until fetch acks.
module wb_retire_buffer
   import wb_retire_params::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4,
   parameter int PC_WIDTH   = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PC_WIDTH-1:0]       in_pc,
   input  logic                      in_rf_we,
   input  logic [ADDR_WIDTH-1:0]     in_rf_addr,
   input  logic [DATA_WIDTH/8-1:0]   in_rf_strobe,
   input  logic [DATA_WIDTH-1:0]     in_result,
   input  logic                      in_exc_valid,
   input  logic [4:0]                in_exc_code,
   input  logic                      in_delay_slot,
   input  logic                      in_eret,
   input  logic                      in_cp0_we,
   input  logic [4:0]                in_cp0_addr,
   input  logic [2:0]                in_cp0_sel,
   input  logic                      rf_grant,
   output logic                      rf_we,
   output logic [ADDR_WIDTH-1:0]     rf_addr,
   output logic [DATA_WIDTH/8-1:0]   rf_strobe,
   output logic [DATA_WIDTH-1:0]     rf_data,
   output logic                      cp0_we,
   output logic [4:0]                cp0_addr,
   output logic [2:0]                cp0_sel,
   output logic [DATA_WIDTH-1:0]     cp0_wdata,
   output logic                      cp0_exc_valid,
   output logic [PC_WIDTH-1:0]       cp0_exc_pc,
   output logic [4:0]                cp0_exc_code,
   output logic                      cp0_delay_slot,
   output logic                      cp0_eret,
   output logic                      flush,
   input  logic                      flush_ack,
   input  logic [ADDR_WIDTH-1:0]     fwd_addr,
   output logic                      fwd_hit,
   output logic [DATA_WIDTH/8-1:0]   fwd_strobe,
   output logic [DATA_WIDTH-1:0]     fwd_data,
   output logic [PC_WIDTH-1:0]       debug_pc,
   output logic [DATA_WIDTH/8-1:0]   debug_rf_we,
   output logic [ADDR_WIDTH-1:0]     debug_rf_addr,
   output logic [DATA_WIDTH-1:0]     debug_rf_data
);

   localparam int STRB = DATA_WIDTH / 8;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic                  rf_we;
      logic [ADDR_WIDTH-1:0] rf_addr;
      logic [STRB-1:0]       rf_strobe;
      logic [DATA_WIDTH-1:0] result;
      WBCtrl                 ctrl;
   } WBEntry;

   WBEntry        mem [DEPTH];
   WBEntry        in_entry, head;
   RetireState    state;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          head_valid, special, commit, push, drop_all;

   assign in_entry = '{pc: in_pc, rf_we: in_rf_we, rf_addr: in_rf_addr,
                       rf_strobe: in_rf_strobe, result: in_result,
                       ctrl: '{exc_valid: in_exc_valid, exc_code: in_exc_code,
                               delay_slot: in_delay_slot, eret: in_eret,
                               cp0_we: in_cp0_we, cp0_addr: in_cp0_addr,
                               cp0_sel: in_cp0_sel}};

   assign head       = mem[rd_ptr];
   // Reset gates the head so a mid-operation reset never writes RF or CP0.
   assign head_valid = !reset && state == RUN && count != '0;
   assign special    = head.ctrl.exc_valid || head.ctrl.eret;
   assign commit     = head_valid && (special || !head.rf_we || rf_grant);
   assign drop_all   = commit && special;
   assign in_ready   = !reset && state == RUN && count != CW'(DEPTH);
   assign push       = in_valid && in_ready;

   assign rf_we     = commit && head.rf_we && !special;
   assign rf_addr   = rf_we ? head.rf_addr   : '0;
   assign rf_strobe = rf_we ? head.rf_strobe : '0;
   assign rf_data   = rf_we ? head.result    : '0;

   assign cp0_we    = commit && head.ctrl.cp0_we && !special;
   assign cp0_addr  = cp0_we ? head.ctrl.cp0_addr : '0;
   assign cp0_sel   = cp0_we ? head.ctrl.cp0_sel  : '0;
   assign cp0_wdata = cp0_we ? head.result        : '0;

   assign cp0_exc_valid  = commit && head.ctrl.exc_valid;
   assign cp0_exc_pc     = cp0_exc_valid ? head.pc              : '0;
   assign cp0_exc_code   = cp0_exc_valid ? head.ctrl.exc_code   : '0;
   assign cp0_delay_slot = cp0_exc_valid && head.ctrl.delay_slot;
   assign cp0_eret       = commit && head.ctrl.eret && !head.ctrl.exc_valid;

   assign flush = !reset && state == FLUSH;

   assign debug_pc      = head_valid ? head.pc : '0;
   assign debug_rf_we   = {STRB{rf_we}} & rf_strobe;
   assign debug_rf_addr = rf_addr;
   assign debug_rf_data = rf_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= RUN;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         case (state)
            RUN: begin
               // An entry pushed alongside a retiring exception is younger, so it
               // is discarded with the rest.
               if (drop_all) begin
                  rd_ptr <= wr_ptr;
                  count  <= '0;
                  state  <= FLUSH;
               end else begin
                  if (push)   wr_ptr <= wr_ptr + 1'b1;
                  if (commit) rd_ptr <= rd_ptr + 1'b1;
                  count <= count + CW'(push) - CW'(commit);
               end
            end
            FLUSH: if (flush_ack) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && !drop_all) mem[wr_ptr] <= in_entry;
   end

   logic [DEPTH-1:0]                 ent_fwd;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
   logic [DEPTH-1:0][STRB-1:0]       ent_strobe;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_fwd[i]    = mem[i].rf_we && !mem[i].ctrl.exc_valid;
         ent_addr[i]   = mem[i].rf_addr;
         ent_strobe[i] = mem[i].rf_strobe;
         ent_data[i]   = mem[i].result;
      end
   end

   wb_forward_merge #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
   ) u_fwd (
      .rd_ptr    (rd_ptr),
      .count     (reset ? CW'(0) : count),
      .ent_fwd   (ent_fwd),
      .ent_addr  (ent_addr),
      .ent_strobe(ent_strobe),
      .ent_data  (ent_data),
      .fwd_addr  (fwd_addr),
      .fwd_hit   (fwd_hit),
      .fwd_strobe(fwd_strobe),
      .fwd_data  (fwd_data)
   );

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Bench for wb_retire_buffer: directed scenarios plus random traffic checked
// every cycle against a queue-based retire model.
module tb_wb_retire_buffer;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] in_pc;
   logic        in_rf_we;
   logic [4:0]  in_rf_addr;
   logic [3:0]  in_rf_strobe;
   logic [31:0] in_result;
   logic        in_exc_valid;
   logic [4:0]  in_exc_code;
   logic        in_delay_slot, in_eret, in_cp0_we;
   logic [4:0]  in_cp0_addr;
   logic [2:0]  in_cp0_sel;
   logic        rf_grant;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [3:0]  rf_strobe;
   logic [31:0] rf_data;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [2:0]  cp0_sel;
   logic [31:0] cp0_wdata;
   logic        cp0_exc_valid;
   logic [31:0] cp0_exc_pc;
   logic [4:0]  cp0_exc_code;
   logic        cp0_delay_slot, cp0_eret, flush, flush_ack;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [3:0]  fwd_strobe;
   logic [31:0] fwd_data;
   logic [31:0] debug_pc;
   logic [3:0]  debug_rf_we;
   logic [4:0]  debug_rf_addr;
   logic [31:0] debug_rf_data;

   wb_retire_buffer dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_addr(in_rf_addr),
      .in_rf_strobe(in_rf_strobe), .in_result(in_result),
      .in_exc_valid(in_exc_valid), .in_exc_code(in_exc_code),
      .in_delay_slot(in_delay_slot), .in_eret(in_eret), .in_cp0_we(in_cp0_we),
      .in_cp0_addr(in_cp0_addr), .in_cp0_sel(in_cp0_sel), .rf_grant(rf_grant),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_strobe(rf_strobe), .rf_data(rf_data),
      .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_sel(cp0_sel),
      .cp0_wdata(cp0_wdata), .cp0_exc_valid(cp0_exc_valid),
      .cp0_exc_pc(cp0_exc_pc), .cp0_exc_code(cp0_exc_code),
      .cp0_delay_slot(cp0_delay_slot), .cp0_eret(cp0_eret), .flush(flush),
      .flush_ack(flush_ack), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
      .fwd_strobe(fwd_strobe), .fwd_data(fwd_data), .debug_pc(debug_pc),
      .debug_rf_we(debug_rf_we), .debug_rf_addr(debug_rf_addr),
      .debug_rf_data(debug_rf_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  addr;
      logic [3:0]  strb;
      logic [31:0] res;
      logic        exc;
      logic [4:0]  code;
      logic        ds;
      logic        eret;
      logic        cp0_we;
      logic [4:0]  cp0_addr;
      logic [2:0]  sel;
   } ent_t;

   ent_t q[$];
   bit   m_flush = 1'b0;
   int   tests = 0, fails = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t zero_ent();
      ent_t e;
      e = '{pc: 0, rf_we: 0, addr: 0, strb: 0, res: 0, exc: 0, code: 0, ds: 0,
            eret: 0, cp0_we: 0, cp0_addr: 0, sel: 0};
      return e;
   endfunction

   function automatic ent_t mk(logic [31:0] pc, logic [4:0] a, logic [3:0] s, logic [31:0] r);
      ent_t e = zero_ent();
      e.pc = pc; e.rf_we = 1'b1; e.addr = a; e.strb = s; e.res = r;
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      ent_t e = zero_ent();
      int   k = int'($urandom_range(0, 15));
      e.pc = $urandom; e.rf_we = ($urandom_range(0, 3) != 0);
      e.addr = 5'($urandom_range(0, 7)); e.strb = 4'($urandom); e.res = $urandom;
      e.exc = (k == 0); e.code = 5'($urandom); e.ds = 1'($urandom);
      e.eret = (k == 1); e.cp0_we = (k == 2 || k == 3);
      e.cp0_addr = 5'($urandom); e.sel = 3'($urandom);
      return e;
   endfunction

   task automatic drive(ent_t e, logic v);
      in_valid = v; in_pc = e.pc; in_rf_we = e.rf_we; in_rf_addr = e.addr;
      in_rf_strobe = e.strb; in_result = e.res; in_exc_valid = e.exc;
      in_exc_code = e.code; in_delay_slot = e.ds; in_eret = e.eret;
      in_cp0_we = e.cp0_we; in_cp0_addr = e.cp0_addr; in_cp0_sel = e.sel;
   endtask

   function automatic ent_t cur_in();
      ent_t e;
      e = '{pc: in_pc, rf_we: in_rf_we, addr: in_rf_addr, strb: in_rf_strobe,
            res: in_result, exc: in_exc_valid, code: in_exc_code, ds: in_delay_slot,
            eret: in_eret, cp0_we: in_cp0_we, cp0_addr: in_cp0_addr, sel: in_cp0_sel};
      return e;
   endfunction

   // Check every output against the model, then advance one clock.
   task automatic cycle();
      ent_t        h;
      bit          hv, sp, cm, rw, cw, rdy, push;
      logic [3:0]  fs;
      logic [31:0] fd;
      #1;
      hv = !reset && !m_flush && q.size() > 0;
      h  = hv ? q[0] : zero_ent();
      sp = hv && (h.exc || h.eret);
      cm = hv && (sp || !h.rf_we || rf_grant);
      rw = cm && h.rf_we && !sp;
      cw = cm && h.cp0_we && !sp;
      rdy  = !reset && !m_flush && q.size() < D;
      push = in_valid && rdy;
      fs = '0; fd = '0;
      if (!reset && fwd_addr != 0)
         for (int b = 0; b < 4; b++)
            for (int i = q.size() - 1; i >= 0; i--)
               if (q[i].rf_we && !q[i].exc && q[i].addr == fwd_addr && q[i].strb[b]) begin
                  fs[b] = 1'b1; fd[b*8 +: 8] = q[i].res[b*8 +: 8];
                  break;
               end
      chk("in_ready", in_ready, rdy);
      chk("rf_we", rf_we, rw);
      chk("rf_addr", rf_addr, rw ? h.addr : 5'd0);
      chk("rf_strobe", rf_strobe, rw ? h.strb : 4'd0);
      chk("rf_data", rf_data, rw ? h.res : 32'd0);
      chk("debug_rf_we", debug_rf_we, rw ? h.strb : 4'd0);
      chk("debug_pc", debug_pc, h.pc);
      chk("cp0_we", cp0_we, cw);
      chk("cp0_addr", {cp0_addr, cp0_sel}, cw ? {h.cp0_addr, h.sel} : 8'd0);
      chk("cp0_wdata", cp0_wdata, cw ? h.res : 32'd0);
      chk("cp0_exc_valid", cp0_exc_valid, cm && h.exc);
      chk("cp0_exc_info", {cp0_exc_pc, cp0_exc_code, cp0_delay_slot},
          (cm && h.exc) ? {h.pc, h.code, h.ds} : 38'd0);
      chk("cp0_eret", cp0_eret, cm && h.eret);
      chk("flush", flush, !reset && m_flush);
      chk("fwd_hit", fwd_hit, |fs);
      chk("fwd_strobe", fwd_strobe, fs);
      chk("fwd_data", fwd_data, fd);
      @(posedge clock);
      if (reset) begin
         q.delete(); m_flush = 1'b0;
      end else if (m_flush) begin
         if (flush_ack) m_flush = 1'b0;
      end else if (cm && sp) begin
         q.delete(); m_flush = 1'b1;
      end else begin
         if (cm) void'(q.pop_front());
         if (push) q.push_back(cur_in());
      end
      @(negedge clock);
   endtask

   task automatic idle();
      drive(zero_ent(), 1'b0);
   endtask

   ent_t e;

   initial begin
      reset = 1'b1; rf_grant = 1'b0; flush_ack = 1'b0; fwd_addr = '0;
      idle();
      @(negedge clock);
      cycle(); cycle();
      reset = 1'b0;
      cycle();

      // Single retire with grant held.
      rf_grant = 1'b1;
      drive(mk(32'hBFC00000, 5'd5, 4'hF, 32'h12345678), 1'b1);
      cycle();
      idle(); #1;
      chk("single_rf_we", rf_we, 1'b1);
      chk("single_rf_addr", rf_addr, 5'd5);
      chk("single_rf_data", rf_data, 32'h12345678);
      chk("single_debug_we", debug_rf_we, 4'hF);
      cycle();
      chk("single_empty", debug_pc, 32'd0);

      // Backpressure: fill with grant low, then drain in order.
      rf_grant = 1'b0;
      for (int i = 0; i < D; i++) begin
         drive(mk(32'h100 + 32'(i), 5'(i + 1), 4'hF, 32'hC0DE0000 + 32'(i)), 1'b1);
         cycle();
      end
      idle(); #1;
      chk("full_ready", in_ready, 1'b0);
      rf_grant = 1'b1;
      #1 chk("drain_first", rf_data, 32'hC0DE0000);
      cycle();
      #1 chk("ready_after_pop", in_ready, 1'b1);
      for (int i = 0; i < D; i++) cycle();

      // Forwarding merge, youngest byte wins.
      rf_grant = 1'b0;
      drive(mk(32'h200, 5'd3, 4'hF, 32'hAAAAAAAA), 1'b1); cycle();
      drive(mk(32'h204, 5'd3, 4'h1, 32'h000000BB), 1'b1); cycle();
      idle(); fwd_addr = 5'd3; #1;
      chk("fwd_merge_hit", fwd_hit, 1'b1);
      chk("fwd_merge_strobe", fwd_strobe, 4'hF);
      chk("fwd_merge_data", fwd_data, 32'hAAAAAABB);
      fwd_addr = 5'd0; #1;
      chk("fwd_zero_hit", fwd_hit, 1'b0);
      cycle();
      rf_grant = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Exception retire, younger entry dropped, flush held until ack.
      drive(mk(32'h300, 5'd2, 4'hF, 32'h11111111), 1'b1); cycle();
      e = zero_ent(); e.pc = 32'hBFC00010; e.exc = 1'b1; e.code = 5'h0C; e.ds = 1'b1;
      drive(e, 1'b1); cycle();
      drive(mk(32'h308, 5'd4, 4'hF, 32'h33333333), 1'b1); #1;
      chk("exc_valid", cp0_exc_valid, 1'b1);
      chk("exc_pc", cp0_exc_pc, 32'hBFC00010);
      chk("exc_code", cp0_exc_code, 5'h0C);
      chk("exc_ds", cp0_delay_slot, 1'b1);
      chk("exc_no_rf", rf_we, 1'b0);
      cycle();
      idle(); #1;
      chk("flush_set", flush, 1'b1);
      chk("flush_not_ready", in_ready, 1'b0);
      cycle(); cycle();
      flush_ack = 1'b1; cycle(); flush_ack = 1'b0;
      #1 chk("flush_cleared", flush, 1'b0);
      cycle();

      // eret ignores grant.
      rf_grant = 1'b0;
      e = mk(32'h400, 5'd6, 4'hF, 32'h5); e.eret = 1'b1;
      drive(e, 1'b1); cycle();
      idle(); #1;
      chk("eret_pulse", cp0_eret, 1'b1);
      cycle();
      chk("eret_one_cycle", cp0_eret, 1'b0);
      chk("eret_flush", flush, 1'b1);
      flush_ack = 1'b1; cycle(); flush_ack = 1'b0;

      // mtc0 retire.
      e = zero_ent(); e.pc = 32'h500; e.cp0_we = 1'b1; e.cp0_addr = 5'd12; e.res = 32'h1;
      drive(e, 1'b1); cycle();
      idle(); #1;
      chk("mtc0_we", cp0_we, 1'b1);
      chk("mtc0_addr", cp0_addr, 5'd12);
      chk("mtc0_data", cp0_wdata, 32'h1);
      cycle();

      // Reset with entries buffered, then reset during FLUSH.
      for (int i = 0; i < 3; i++) begin
         drive(mk(32'h600 + 32'(i), 5'd7, 4'hF, 32'(i)), 1'b1); cycle();
      end
      idle(); rf_grant = 1'b1; reset = 1'b1; #1;
      chk("reset_no_rf", rf_we, 1'b0);
      cycle(); reset = 1'b0;
      #1 chk("reset_ready", in_ready, 1'b1);
      e = zero_ent(); e.exc = 1'b1; drive(e, 1'b1); cycle();
      idle(); cycle();
      chk("pre_reset_flush", flush, 1'b1);
      reset = 1'b1; cycle(); reset = 1'b0;
      #1 chk("reset_flush_clear", flush, 1'b0);
      cycle();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         drive(rnd_ent(), $urandom_range(0, 9) < 7);
         rf_grant  = $urandom_range(0, 9) < 6;
         flush_ack = 1'($urandom);
         fwd_addr  = 5'($urandom_range(0, 7));
         reset     = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
